// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, fetch-queue payload, PC step.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch queue of {pc, inst} entries with flush, same-cycle push/pop and occupancy count.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_wdata,
  input  logic         i_pop,
  output fetch_entry_t o_rdata,
  output logic [CW-1:0] o_count
);

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_wr_en = i_push & (~w_full | i_pop) & ~i_flush;
  assign w_rd_en = i_pop & ~w_empty & ~i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; validity is tracked solely by the count.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, fetches from combinational imem into a small queue,
// and hands {pc, inst} to decode over valid/ready; execute redirects flush and restart.
module inst_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        redirect_i,
  input  logic [XLEN-1:0]             redirect_pc_i,
  output logic [XLEN-1:0]             imem_addr_o,
  input  logic [INST_W-1:0]           imem_inst_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [INST_W-1:0]           inst_o,
  output logic [XLEN-1:0]             pc_o,
  output logic [$clog2(FQ_DEPTH):0]   fq_count_o
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] r_pc;

  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;
  logic [CW-1:0]   w_count;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [XLEN-1:0] w_target;

  assign w_valid  = (w_count != '0);
  assign w_pop    = w_valid & ready_i;
  assign w_push   = ~redirect_i & ((w_count < CW'(FQ_DEPTH)) | w_pop);
  assign w_target = redirect_pc_i & ~XLEN'(3);
  assign w_wdata  = '{pc: r_pc, inst: imem_inst_i};

  // Redirect wins over sequential advance; PC holds while the queue is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= w_target;
    end else if (w_push) begin
      r_pc <= r_pc + XLEN'(PC_STEP);
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign imem_addr_o = r_pc >> 2;
  assign valid_o     = w_valid;
  assign inst_o      = w_valid ? w_head.inst : '0;
  assign pc_o        = w_valid ? w_head.pc   : '0;
  assign fq_count_o  = w_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomised self-checking bench for inst_fetch_unit against a queue-based reference model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [1:0]  fq_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: next PC to fetch and queue of buffered PCs.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0320_0793;
  endfunction

  assign imem_inst = mem_word(imem_addr);

  inst_fetch_unit #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_inst_i   (imem_inst),
    .valid_o       (valid),
    .ready_i       (ready),
    .inst_o        (inst),
    .pc_o          (pc),
    .fq_count_o    (fq_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic        e_valid;
    logic [31:0] e_pc;
    e_valid = (m_q.size() != 0);
    e_pc    = e_valid ? m_q[0] : 32'h0;
    chk("valid", {31'h0, valid}, {31'h0, e_valid});
    chk("pc", pc, e_pc);
    chk("inst", inst, e_valid ? mem_word(e_pc >> 2) : 32'h0);
    chk("count", {30'h0, fq_count}, 32'(m_q.size()));
    chk("imem_addr", imem_addr, m_pc >> 2);
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_pc = RESET_PC;
  endfunction

  // One cycle: drive at negedge, check settled outputs, then advance the model at posedge.
  task automatic step(input logic rd, input logic [31:0] tgt, input logic rdy);
    logic e_pop;
    @(negedge clk);
    rst         = 1'b0;
    redirect    = rd;
    redirect_pc = tgt;
    ready       = rdy;
    #1;
    check_model();
    e_pop = (m_q.size() != 0) && rdy;
    @(posedge clk);
    if (rd) begin
      m_q.delete();
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_q.size() < DEPTH) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Asynchronous reset between edges; outputs must drop before any clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_count", {30'h0, fq_count}, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC >> 2);
    model_reset();
    @(posedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ready       = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("init_valid", {31'h0, valid}, 32'h0);
    chk("init_pc", pc, 32'h0);
    chk("init_inst", inst, 32'h0);
    chk("init_addr", imem_addr, RESET_PC >> 2);

    // First fetch and streaming.
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("first_inst", inst, 32'h0320_0793);
    repeat (4) step(1'b0, 32'h0, 1'b1);

    // Mid-stream reset, then backpressure from reset.
    mid_reset();
    repeat (5) step(1'b0, 32'h0, 1'b0);
    chk("bp_count", {30'h0, fq_count}, 32'd2);
    chk("bp_addr", imem_addr, 32'd2);
    repeat (5) step(1'b0, 32'h0, 1'b1);

    // Redirect while full, with the low address bits discarded.
    repeat (3) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h102, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("redir_addr", imem_addr, 32'h40);
    repeat (3) step(1'b0, 32'h0, 1'b1);

    // Redirect with concurrent pop, and a redirect held several cycles.
    step(1'b1, 32'h200, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 32'h0000_1000, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1);

    // PC wrap across 2^32.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (5) step(1'b0, 32'h0, 1'b1);

    // Randomised traffic with occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) mid_reset();
      step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch unit for the RISC-V core. It owns the program counter and drives word addresses into the combinational read-only instruction memory. It buffers each fetched `{pc, instruction}` pair in a small queue and hands them to decode over a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch at the target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word-aligned.
- `FQ_DEPTH`, default 2: fetch-queue entries. Must be a power of two, ≥ 2.

Ports:
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `redirect_i` in 1: redirect request from execute (taken branch/jump).
- `redirect_pc_i` in 32: redirect target byte address.
- `imem_addr_o` out 32: word index to instruction memory, equal to `pc >> 2`. Combinational from the PC register.
- `imem_inst_i` in 32: instruction word returned combinationally in the same cycle.
- `valid_o` out 1: queue head holds a valid instruction.
- `ready_i` in 1: decode accepts the head this cycle.
- `inst_o` out 32: head instruction; forced to 0 when `valid_o`=0.
- `pc_o` out 32: byte PC of the head instruction; forced to 0 when `valid_o`=0.
- `fq_count_o` out $clog2(FQ_DEPTH)+1: current queue occupancy.

## Operation
- State: `pc` register (32 b), fetch queue of `FQ_DEPTH` entries of `{pc, inst}`, plus read pointer, write pointer and count.
- `pop = valid_o & ready_i`.
- `push = !redirect_i & (count < FQ_DEPTH | pop)`.
  - On push, the queue captures `{pc, imem_inst_i}` and `pc <= pc + 4`, wrapping modulo 2^32.
  - With no push and no redirect, `pc` holds.
- Redirect, which has priority over push:
  - Queue is flushed: count=0 and pointers reset.
  - `pc <= {redirect_pc_i[31:2], 2'b00}`; the low two bits are always discarded.
  - No push occurs in the redirect cycle.
- Simultaneous redirect and pop:
  - The handshake is complete; decode has taken the head.
  - The flush still applies, so the final count is 0.
- Simultaneous push and pop with a full queue is legal. Count stays at `FQ_DEPTH`.
- Queue pointers wrap modulo `FQ_DEPTH`. The count never exceeds `FQ_DEPTH` and never underflows.
- Reset, asynchronous and applicable mid-stream:
  - `pc` = `RESET_PC`, count=0, pointers=0.
  - Outputs: `valid_o`=0, `inst_o`=0, `pc_o`=0, `fq_count_o`=0, `imem_addr_o`=`RESET_PC>>2`.
  - Queue storage need not be cleared.
- There is no explicit FSM. Behaviour is fully determined by count in {EMPTY: 0, PARTIAL: 1..FQ_DEPTH-1, FULL: FQ_DEPTH} and by `redirect_i`.

## Timing
- Fetch-to-valid latency is one cycle:
  - An instruction fetched in cycle N appears on `inst_o`/`pc_o` with `valid_o`=1 in cycle N+1.
- After reset release, the first rising edge pushes `RESET_PC`. `valid_o` rises the cycle after that edge.
- Steady state with `ready_i`=1 is one instruction per cycle with consecutive PCs.
- Backpressure (`ready_i`=0):
  - The queue fills in `FQ_DEPTH` cycles.
  - Once full, `imem_addr_o` freezes on the next unfetched PC.
  - On release, there are no duplicates and no skips.
- Redirect penalty is a one-cycle bubble:
  - `redirect_i` sampled at edge E.
  - Cycle after E: `valid_o`=0, `imem_addr_o`=target>>2.
  - Target instruction valid after edge E+1.
- `redirect_i` held for multiple cycles re-flushes every cycle. `valid_o` stays 0 until the cycle after its deassertion edge.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`=32 and `INST_W`=32.
  - Typedef `fetch_entry_t` as a packed struct `{logic [31:0] pc; logic [31:0] inst;}`.
  - Constant `PC_STEP`=4.
- One sub-module is natural: `fetch_fifo`.
  - A parameterised synchronous FIFO of `fetch_entry_t` with flush, same-cycle push/pop and a count output.
  - `inst_fetch_unit` keeps the PC register, push/redirect logic and output gating.

## Test plan
- Reset and first fetch: memory word 0 = 32'h0320_0793, `rst_i`=1 → `valid_o`=0, `pc_o`=0, `inst_o`=0, `imem_addr_o`=0. Release, `ready_i`=1 → one edge later `valid_o`=1, `pc_o`=0, `inst_o`=32'h0320_0793.
- Streaming, `ready_i`=1 throughout → `pc_o` = 0x0, 0x4, 0x8, 0xC on consecutive cycles and `imem_addr_o` = 0,1,2,3 one cycle ahead.
- Backpressure, `ready_i`=0 for 5 cycles after reset → `fq_count_o` saturates at 2 and `imem_addr_o` holds 2. Then `ready_i`=1 → accepted PCs are exactly 0x0, 0x4, 0x8, 0xC.
- Redirect while full: `redirect_i`=1, `redirect_pc_i`=32'h102 → next cycle `valid_o`=0, `fq_count_o`=0, `imem_addr_o`=0x40. Then `pc_o` = 0x100, 0x104.
- Redirect with concurrent pop (`valid_o`=1, `ready_i`=1, redirect to 0x200) → the head counts as accepted, queue is empty next cycle, then `pc_o`=0x200.
- Mid-stream reset: assert `rst_i` between edges at PC 0x10 → `valid_o`, `pc_o`, `fq_count_o` drop to 0 immediately without waiting for an edge, and `imem_addr_o`=`RESET_PC>>2`. After release, the sequence restarts at `RESET_PC`.
